// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline; one arbitration point for all
// pipeline register enables. Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned FREEZE_LIMIT = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [4:0]  ID_RS1,
   input  logic [4:0]  ID_RS2,
   input  logic        ID_USES_RS1,
   input  logic        ID_USES_RS2,
   input  logic [4:0]  EX_RD,
   input  logic        EX_MEM_READ,
   input  logic        EX_BRANCH_TAKEN,
   input  logic        IMEM_BUSY,
   input  logic        DMEM_BUSY,
   output logic        PC_WRITE,
   output logic        IFID_WRITE,
   output logic        IDEX_WRITE,
   output logic        EXMEM_WRITE,
   output logic        MEMWB_WRITE,
   output logic        IFID_FLUSH,
   output logic        IDEX_FLUSH,
   output logic        BUSY_WAIT,
   output logic [1:0]  STATE,
   output logic        FREEZE_TIMEOUT,
   output logic [31:0] STALL_CNT,
   output logic [31:0] FLUSH_CNT
);

   typedef enum logic [1:0] {StRun = 2'd0, StFreeze = 2'd1} state_e;

   state_e      state_q, state_d;
   logic        pend_flush_q, pend_flush_d;
   logic [15:0] freeze_cnt_q, freeze_cnt_d;
   logic        timeout_q, timeout_d;
   logic        busy, br, lu;

   assign busy = IMEM_BUSY | DMEM_BUSY;
   assign br   = EX_BRANCH_TAKEN | pend_flush_q;
   assign lu   = EX_MEM_READ & (EX_RD != 5'd0) &
                 ((ID_USES_RS1 & (ID_RS1 == EX_RD)) | (ID_USES_RS2 & (ID_RS2 == EX_RD)));

   always_comb begin
      PC_WRITE     = 1'b1;
      IFID_WRITE   = 1'b1;
      IDEX_WRITE   = 1'b1;
      EXMEM_WRITE  = 1'b1;
      MEMWB_WRITE  = 1'b1;
      IFID_FLUSH   = 1'b0;
      IDEX_FLUSH   = 1'b0;
      BUSY_WAIT    = 1'b0;
      state_d      = StRun;
      pend_flush_d = pend_flush_q;
      freeze_cnt_d = 16'd0;
      timeout_d    = timeout_q;
      if (!RESET) begin
         PC_WRITE     = 1'b0;
         IFID_WRITE   = 1'b0;
         IDEX_WRITE   = 1'b0;
         EXMEM_WRITE  = 1'b0;
         MEMWB_WRITE  = 1'b0;
         IFID_FLUSH   = 1'b1;
         IDEX_FLUSH   = 1'b1;
         pend_flush_d = 1'b0;
         timeout_d    = 1'b0;
      end else if (busy) begin
         PC_WRITE     = 1'b0;
         IFID_WRITE   = 1'b0;
         IDEX_WRITE   = 1'b0;
         EXMEM_WRITE  = 1'b0;
         MEMWB_WRITE  = 1'b0;
         BUSY_WAIT    = 1'b1;
         state_d      = StFreeze;
         // A branch seen while frozen is replayed on the first free cycle.
         pend_flush_d = pend_flush_q | EX_BRANCH_TAKEN;
         if (state_q != StFreeze) begin
            freeze_cnt_d = 16'd1;
         end else if (freeze_cnt_q == 16'hFFFF) begin
            freeze_cnt_d = freeze_cnt_q;
         end else begin
            freeze_cnt_d = freeze_cnt_q + 16'd1;
         end
         if (freeze_cnt_d == 16'(FREEZE_LIMIT)) begin
            timeout_d = 1'b1;
         end
      end else if (br) begin
         IFID_FLUSH   = 1'b1;
         IDEX_FLUSH   = 1'b1;
         pend_flush_d = 1'b0;
      end else if (lu) begin
         PC_WRITE   = 1'b0;
         IFID_WRITE = 1'b0;
         IDEX_FLUSH = 1'b1;
      end
   end

   // Debug view reflects the decision taken this cycle.
   assign STATE          = state_d;
   assign FREEZE_TIMEOUT = timeout_q;

   always_ff @(posedge CLK) begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
      freeze_cnt_q <= freeze_cnt_d;
      timeout_q    <= timeout_d;
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (!PC_WRITE)  stall_cnt_q <= stall_cnt_q + 32'd1;
         if (IFID_FLUSH) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign STALL_CNT = stall_cnt_q;
   assign FLUSH_CNT = flush_cnt_q;
`else
   assign STALL_CNT = 32'd0;
   assign FLUSH_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver pushes model expectations, monitor checks.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned LIMIT = 4;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [4:0]  ID_RS1, ID_RS2, EX_RD;
   logic        ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_BRANCH_TAKEN, IMEM_BUSY, DMEM_BUSY;
   logic        PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE, MEMWB_WRITE;
   logic        IFID_FLUSH, IDEX_FLUSH, BUSY_WAIT, FREEZE_TIMEOUT;
   logic [1:0]  STATE;
   logic [31:0] STALL_CNT, FLUSH_CNT;

   pipeline_hazard_ctrl #(.FREEZE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .RESET(RESET), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1),
      .ID_USES_RS2(ID_USES_RS2), .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ),
      .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY),
      .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE), .IDEX_WRITE(IDEX_WRITE),
      .EXMEM_WRITE(EXMEM_WRITE), .MEMWB_WRITE(MEMWB_WRITE), .IFID_FLUSH(IFID_FLUSH),
      .IDEX_FLUSH(IDEX_FLUSH), .BUSY_WAIT(BUSY_WAIT), .STATE(STATE),
      .FREEZE_TIMEOUT(FREEZE_TIMEOUT), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
   );

   always #5 CLK = ~CLK;

   // ctl = {pc,ifid,idex,exmem,memwb writes, ifid_flush, idex_flush, busy_wait, state[1:0], timeout}
   typedef struct packed {
      logic [10:0] ctl;
      logic [31:0] stall;
      logic [31:0] flush;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   bit          m_pend = 0;
   int unsigned m_run  = 0;
   bit          m_to   = 0;
   logic [31:0] m_stall = '0;
   logic [31:0] m_flush = '0;

   task automatic drive(input bit rst_n, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit mr, input bit bt, input bit ib, input bit db);
      exp_t e;
      bit   busy, br, lu;
      @(posedge CLK);
      #1;
      RESET = rst_n; ID_RS1 = 5'(rs1); ID_RS2 = 5'(rs2); ID_USES_RS1 = u1; ID_USES_RS2 = u2;
      EX_RD = 5'(rd); EX_MEM_READ = mr; EX_BRANCH_TAKEN = bt; IMEM_BUSY = ib; DMEM_BUSY = db;
      busy = ib | db;
      br   = bt | m_pend;
      lu   = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
`ifdef HAZARD_PERF_CNT_EN
      e.stall = m_stall;
      e.flush = m_flush;
`else
      e.stall = '0;
      e.flush = '0;
`endif
      if (!rst_n) begin
         e.ctl = {5'b00000, 2'b11, 1'b0, 2'd0, m_to};
         m_pend = 0; m_run = 0; m_to = 0; m_stall = '0; m_flush = '0;
      end else if (busy) begin
         e.ctl = {5'b00000, 2'b00, 1'b1, 2'd1, m_to};
         m_pend = m_pend | bt;
         if (m_run < 65535) m_run++;
         if (m_run == LIMIT) m_to = 1;
         m_stall++;
      end else if (br) begin
         e.ctl = {5'b11111, 2'b11, 1'b0, 2'd0, m_to};
         m_pend = 0; m_run = 0;
         m_flush++;
      end else if (lu) begin
         e.ctl = {5'b00111, 2'b01, 1'b0, 2'd0, m_to};
         m_run = 0;
         m_stall++;
      end else begin
         e.ctl = {5'b11111, 2'b00, 1'b0, 2'd0, m_to};
         m_run = 0;
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1, 1, 2, 1, 1, 3, 0, 0, 0, 0);
   endtask

   // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
   always @(negedge CLK) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         logic [10:0] act;
         e   = exp_q.pop_front();
         act = {PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE, MEMWB_WRITE,
                IFID_FLUSH, IDEX_FLUSH, BUSY_WAIT, STATE, FREEZE_TIMEOUT};
         checks++;
         if (act !== e.ctl) begin
            errors++;
            $display("FAIL ctl t=%0t got=%b want=%b", $time, act, e.ctl);
         end
         checks++;
         if (STALL_CNT !== e.stall || FLUSH_CNT !== e.flush) begin
            errors++;
            $display("FAIL perf t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     $time, STALL_CNT, FLUSH_CNT, e.stall, e.flush);
         end
      end
   end

   initial begin
      RESET = 1'b0; ID_RS1 = '0; ID_RS2 = '0; EX_RD = '0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
      EX_MEM_READ = 0; EX_BRANCH_TAKEN = 0; IMEM_BUSY = 0; DMEM_BUSY = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // Load-use, then recovery
      drive(1, 0, 5, 0, 1, 5, 1, 0, 0, 0);
      drive(1, 0, 5, 0, 1, 5, 0, 0, 0, 0);
      // x0 guard
      drive(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      // Branch beats load-use
      drive(1, 0, 5, 0, 1, 5, 1, 1, 0, 0);
      idle(1);
      // Branch during freeze
      drive(1, 1, 2, 1, 1, 3, 0, 0, 0, 1);
      drive(1, 1, 2, 1, 1, 3, 0, 1, 0, 1);
      drive(1, 1, 2, 1, 1, 3, 0, 0, 0, 1);
      drive(1, 1, 2, 1, 1, 3, 0, 0, 0, 0);
      idle(1);
      // Timeout: six busy cycles with limit 4, flag stays sticky
      for (int i = 0; i < 6; i++) drive(1, 1, 2, 1, 1, 3, 0, 0, 1, 0);
      idle(3);
      // Reset mid-freeze drops pending flush and timeout
      drive(1, 1, 2, 1, 1, 3, 0, 1, 0, 1);
      drive(0, 1, 2, 1, 1, 3, 0, 0, 0, 1);
      idle(3);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 99) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
               $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      end
      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge CLK);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending want=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. It watches ID-stage source registers, EX-stage load/branch status and instruction/data memory busy flags. It drives per-register write-enable and flush (bubble) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Because it replaces the scattered BUSY_WAIT gating, every pipeline register obeys one arbitration point.

## Interface
- FREEZE_LIMIT, 255: maximum consecutive freeze cycles before FREEZE_TIMEOUT sets; 1..65535.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low; clock CLK.
- ID_RS1, ID_RS2  in  5  source register indices of the instruction in ID.
- ID_USES_RS1, ID_USES_RS2  in  1  each: the corresponding source is actually read.
- EX_RD  in  5  destination index of the instruction in EX.
- EX_MEM_READ  in  1  EX instruction is a load.
- EX_BRANCH_TAKEN  in  1  branch/jump in EX resolved taken (PC redirect this cycle).
- IMEM_BUSY, DMEM_BUSY  in  1  instruction/data memory not ready.
- PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE, MEMWB_WRITE  out  1  load enable per register.
- IFID_FLUSH, IDEX_FLUSH  out  1  register loads all-zero bubble; dominates WRITE.
- BUSY_WAIT  out  1  global freeze indicator.
- STATE  out  2  debug: 0 RUN, 1 FREEZE.
- FREEZE_TIMEOUT  out  1  sticky error flag.
- STALL_CNT, FLUSH_CNT  out  32  performance counters (only with macro, see Configuration).

## Operation
- Load-use hazard LU = EX_MEM_READ & EX_RD!=0 & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)).
- BUSY = IMEM_BUSY | DMEM_BUSY. BR = EX_BRANCH_TAKEN | PEND_FLUSH.
- Internal registers: state (RUN/FREEZE), PEND_FLUSH (1b), freeze counter (16b).
- Outputs are Mealy, evaluated in priority order in both states:
  1. BUSY: all *_WRITE=0, flushes=0, BUSY_WAIT=1; next state FREEZE; PEND_FLUSH <= PEND_FLUSH | EX_BRANCH_TAKEN.
  2. BR: all *_WRITE=1, IFID_FLUSH=1, IDEX_FLUSH=1; next RUN; PEND_FLUSH <= 0.
  3. LU: PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1, EXMEM_WRITE=MEMWB_WRITE=1; next RUN.
  4. Otherwise: all *_WRITE=1, flushes=0; next RUN.
- BR over LU: the load-dependent ID instruction is squashed anyway.
- A branch observed during a freeze is remembered and applied in the first non-busy cycle, even if EX_BRANCH_TAKEN has dropped.
- Freeze counter: cleared when not in FREEZE. Increments every FREEZE cycle with BUSY, saturating at 65535. FREEZE_TIMEOUT sets when the counter reaches FREEZE_LIMIT. It clears only on reset. The pipeline keeps waiting regardless.

## Timing
- Reset (RESET==0 at posedge): state=RUN, PEND_FLUSH=0, freeze counter=0, FREEZE_TIMEOUT=0, counters=0.
- While RESET==0, combinational outputs: all *_WRITE=0, IFID_FLUSH=IDEX_FLUSH=1, BUSY_WAIT=0, STATE=0.
- Reset asserted mid-freeze discards the pending flush and the freeze count.
- Zero-cycle decision latency: controls for edge N depend only on inputs sampled before edge N.
- Load-use costs exactly 1 bubble. Taken branch costs 2 flushed slots. Each busy cycle costs 1 frozen cycle.
- BUSY, BR and LU in the same cycle: freeze, latch the flush, and reissue nothing. The first free cycle flushes, and LU is ignored.
- BUSY dropping with no pending flush: normal RUN priority applies in that same cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - STALL_CNT increments on each non-reset cycle with PC_WRITE=0.
  - FLUSH_CNT increments on each cycle with IFID_FLUSH=1 outside reset.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by reset.
- Undefined: STALL_CNT and FLUSH_CNT ports remain but are tied to 0, and no counter flops are synthesised.

## Test plan
- Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_USES_RS2=1 for one cycle -> PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1 that cycle; next cycle (EX_MEM_READ=0) all writes 1.
- x0 guard: same as above with EX_RD=0, ID_RS1=0 -> no stall, all writes 1.
- Branch vs load-use: EX_BRANCH_TAKEN=1 together with LU -> IFID_FLUSH=IDEX_FLUSH=1, PC_WRITE=1; STALL_CNT unchanged, FLUSH_CNT +1.
- Branch during freeze: DMEM_BUSY=1 for 3 cycles, EX_BRANCH_TAKEN pulsed in cycle 2 -> 3 cycles of all writes 0, BUSY_WAIT=1, STATE=1; cycle 4 gives IFID_FLUSH=IDEX_FLUSH=1, STATE=0.
- Timeout with FREEZE_LIMIT=4: IMEM_BUSY held 6 cycles -> FREEZE_TIMEOUT rises after the 4th freeze cycle and stays 1 after busy drops until RESET=0.
- Reset mid-freeze: RESET=0 during DMEM_BUSY with a pending flush, then release with no busy/branch -> no flush issued; all writes 1, counters 0.
